// File: rtl/accel_pkg.sv
// accel_pkg: shared sample type and default FIFO geometry for the accelerometer sample path.
package accel_pkg;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } accel_sample_t;
  localparam int ACCEL_DEPTH = 16;
  localparam int ACCEL_AW = 4;
endpackage

// File: rtl/sample_ram.sv
// sample_ram: DEPTH x 48 storage, one write port, one registered read port (block-RAM style).
module sample_ram
  import accel_pkg::*;
#(
  parameter int DEPTH = ACCEL_DEPTH,
  parameter int AW = ACCEL_AW
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  accel_sample_t wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output accel_sample_t rdata
);
  accel_sample_t mem [DEPTH];
  always_ff @(posedge sys_clk)
    if (we) mem[waddr] <= wdata;
  // Read-before-write: a same-address read returns the old word, which a full FIFO relies on.
  always_ff @(posedge sys_clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/accel_sample_fifo.sv
// accel_sample_fifo: decimating xyz sample FIFO with sticky error flags and watermark irq.
module accel_sample_fifo
  import accel_pkg::*;
#(
  parameter int DEPTH = ACCEL_DEPTH,
  parameter int AW = ACCEL_AW
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic          sample_strobe,
  input  logic [15:0]   x_in,
  input  logic [15:0]   y_in,
  input  logic [15:0]   z_in,
  input  logic [3:0]    decim,
  input  logic [AW:0]   watermark,
  input  logic          flush,
  input  logic          rd_en,
  output logic          rd_valid,
  output logic [15:0]   rd_x,
  output logic [15:0]   rd_y,
  output logic [15:0]   rd_z,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow,
  input  logic          clr_err,
  output logic          irq
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] lvl_n;
  logic [3:0] dcnt, dlim_q, dlim;
  logic kept, rd_ok, wr_ok, ovf_set, udf_set, above_c, above_n;
  accel_sample_t rd_s;
  assign empty = level == '0;
  assign full = level == FULL_LVL;
  // The decim value is latched at the start of each period so mid-period changes wait for the wrap.
  assign dlim = dcnt == '0 ? decim : dlim_q;
  assign kept = sample_strobe && dcnt == '0;
  assign rd_ok = rd_en && !empty && !flush;
  assign wr_ok = kept && (!full || rd_ok) && !flush;
  assign ovf_set = kept && full && !rd_ok && !flush;
  assign udf_set = rd_en && empty && !flush;
  assign lvl_n = flush ? '0 : level + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
  assign above_c = watermark != '0 && level >= watermark;
  assign above_n = watermark != '0 && lvl_n >= watermark;
  always_ff @(posedge sys_clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      dcnt <= '0;
      dlim_q <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      irq <= 1'b0;
    end else begin
      level <= lvl_n;
      rd_valid <= rd_ok;
      irq <= above_n && !above_c;
      wr_ptr <= flush ? '0 : wr_ptr + AW'(wr_ok);
      rd_ptr <= flush ? '0 : rd_ptr + AW'(rd_ok);
      overflow <= ovf_set || (overflow && !clr_err);
      underflow <= udf_set || (underflow && !clr_err);
      if (flush) dcnt <= '0;
      else if (sample_strobe) begin
        dcnt <= dcnt >= dlim ? '0 : dcnt + 4'd1;
        if (dcnt == '0) dlim_q <= decim;
      end
    end
  sample_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .sys_clk(sys_clk),
    .rst(rst),
    .we(wr_ok),
    .waddr(wr_ptr),
    .wdata({x_in, y_in, z_in}),
    .re(rd_ok),
    .raddr(rd_ptr),
    .rdata(rd_s)
  );
  assign rd_x = rd_s.x;
  assign rd_y = rd_s.y;
  assign rd_z = rd_s.z;
endmodule

// File: tb/tb_accel_sample_fifo.sv
// tb_accel_sample_fifo: scoreboard bench for accel_sample_fifo.
module tb_accel_sample_fifo;
  logic sys_clk, rst, sample_strobe, flush, rd_en, clr_err;
  logic [15:0] x_in, y_in, z_in, rd_x, rd_y, rd_z;
  logic [3:0] decim;
  logic [4:0] watermark, level;
  logic rd_valid, empty, full, overflow, underflow, irq;
  logic [47:0] q[$];
  int n_cmp = 0;
  int n_err = 0;
  accel_sample_fifo dut (
    .sys_clk(sys_clk), .rst(rst), .sample_strobe(sample_strobe),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .decim(decim), .watermark(watermark),
    .flush(flush), .rd_en(rd_en), .rd_valid(rd_valid), .rd_x(rd_x), .rd_y(rd_y),
    .rd_z(rd_z), .level(level), .empty(empty), .full(full), .overflow(overflow),
    .underflow(underflow), .clr_err(clr_err), .irq(irq)
  );
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask
  function automatic logic [47:0] trip(input logic [15:0] v);
    return {v, v + 16'd100, v + 16'd200};
  endfunction
  task automatic set_in(input logic [15:0] v);
    x_in = v;
    y_in = v + 16'd100;
    z_in = v + 16'd200;
  endtask
  task automatic strobe(input logic [15:0] v, input bit keep);
    set_in(v);
    sample_strobe = 1'b1;
    if (keep) q.push_back(trip(v));
    tick();
    sample_strobe = 1'b0;
  endtask
  task automatic pop(input string tag);
    logic [47:0] e;
    e = q.size() != 0 ? q.pop_front() : 48'hx;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check({tag, "_valid"}, 64'(rd_valid), 64'd1);
    check({tag, "_data"}, 64'({rd_x, rd_y, rd_z}), 64'(e));
    tick();
    check({tag, "_valid_pulse"}, 64'(rd_valid), 64'd0);
  endtask
  task automatic check_reset_state(input string tag);
    check({tag, "_level"}, 64'(level), 64'd0);
    check({tag, "_empty"}, 64'(empty), 64'd1);
    check({tag, "_full"}, 64'(full), 64'd0);
    check({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    check({tag, "_flags"}, 64'({overflow, underflow, irq}), 64'd0);
    check({tag, "_rd_data"}, 64'({rd_x, rd_y, rd_z}), 64'd0);
  endtask
  initial begin
    rst = 1'b1; sample_strobe = 1'b0; flush = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    decim = 4'd0; watermark = 5'd0; set_in(16'd0);
    tick(); tick();
    rst = 1'b0;
    check_reset_state("reset");
    for (int i = 0; i < 16; i++) strobe(16'(i), 1'b1);
    check("fill_full", 64'(full), 64'd1);
    check("fill_level", 64'(level), 64'd16);
    check("fill_no_irq", 64'(irq), 64'd0);
    for (int i = 0; i < 16; i++) pop("fill_rd");
    check("fill_empty", 64'(empty), 64'd1);
    for (int i = 0; i < 17; i++) strobe(16'(i), i < 16);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_level", 64'(level), 64'd16);
    pop("ovf_rd0");
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("ovf_clr", 64'(overflow), 64'd0);
    strobe(16'd40, 1'b1);
    check("bnd_full", 64'(full), 64'd1);
    set_in(16'd50); sample_strobe = 1'b1; rd_en = 1'b1;
    q.push_back(trip(16'd50));
    tick();
    sample_strobe = 1'b0; rd_en = 1'b0;
    check("bnd_full_rw_valid", 64'(rd_valid), 64'd1);
    check("bnd_full_rw_data", 64'({rd_x, rd_y, rd_z}), 64'(q.pop_front()));
    check("bnd_full_rw_level", 64'(level), 64'd16);
    check("bnd_full_rw_ovf", 64'(overflow), 64'd0);
    tick();
    while (q.size() != 0) pop("drain_rd");
    check("drain_empty", 64'(empty), 64'd1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("udf_flag", 64'(underflow), 64'd1);
    check("udf_no_valid", 64'(rd_valid), 64'd0);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("udf_clr", 64'(underflow), 64'd0);
    set_in(16'd77); sample_strobe = 1'b1; rd_en = 1'b1;
    q.push_back(trip(16'd77));
    tick();
    sample_strobe = 1'b0; rd_en = 1'b0;
    check("bnd_empty_rw_level", 64'(level), 64'd1);
    check("bnd_empty_rw_udf", 64'(underflow), 64'd1);
    check("bnd_empty_rw_valid", 64'(rd_valid), 64'd0);
    pop("bnd_empty_rd");
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    decim = 4'd3;
    for (int i = 0; i < 12; i++) strobe(16'(i), i % 4 == 0);
    check("dec_level", 64'(level), 64'd3);
    for (int i = 0; i < 3; i++) pop("dec_rd");
    decim = 4'd0;
    watermark = 5'd4;
    for (int i = 0; i < 3; i++) strobe(16'(i), 1'b1);
    check("wm_below", 64'(irq), 64'd0);
    strobe(16'd3, 1'b1);
    check("wm_cross1", 64'(irq), 64'd1);
    tick();
    check("wm_pulse1_end", 64'(irq), 64'd0);
    pop("wm_rd");
    check("wm_level3", 64'(level), 64'd3);
    strobe(16'd4, 1'b1);
    check("wm_cross2", 64'(irq), 64'd1);
    tick();
    check("wm_pulse2_end", 64'(irq), 64'd0);
    watermark = 5'd0;
    flush = 1'b1; tick(); flush = 1'b0;
    q.delete();
    for (int i = 0; i < 7; i++) strobe(16'(i + 20), 1'b1);
    check("flush_pre_level", 64'(level), 64'd7);
    flush = 1'b1; sample_strobe = 1'b1; set_in(16'd99);
    tick();
    flush = 1'b0; sample_strobe = 1'b0;
    q.delete();
    check("flush_level", 64'(level), 64'd0);
    check("flush_empty", 64'(empty), 64'd1);
    tick();
    check("flush_level_hold", 64'(level), 64'd0);
    for (int i = 0; i < 5; i++) strobe(16'(i + 31), 1'b1);
    pop("prerst_rd");
    rst = 1'b1; tick(); rst = 1'b0;
    q.delete();
    check_reset_state("midrst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
